// File: rtl/mask_mem_arbiter.sv
// mask_mem_arbiter
//
// Shares the single port of the 3-bit colour-mask BRAM between the colour
// filter's write stream and a read requester (centroid/display logic).
// Filter writes are queued in a small FIFO so that a read burst never loses
// mask pixels. Reads win arbitration until the FIFO level reaches the
// high-water mark, at which point queued writes take the port.
//
// Optional feature (compile-time macro MASK_ARB_STARVE_EN):
//   A starve counter tracks how long a pending read has been waiting. When
//   it reaches STARVE_LIMIT the read is granted even above the high-water
//   mark. Without the macro no counter exists and reads never override the
//   high-water rule.
//
// Ports:
//   clock       system clock, all logic on the rising edge
//   reset       asynchronous active-high reset
//   filt_we     single-cycle write pulse from the colour filter
//   filt_addr   write address, valid with filt_we
//   filt_data   mask bits {B,G,R}, valid with filt_we
//   rd_req      read request, held with rd_addr until rd_gnt
//   rd_addr     read address
//   rd_gnt      one-cycle grant; the read goes to memory in this cycle
//   rd_valid    one-cycle pulse the cycle after rd_gnt
//   rd_data     read data, valid with rd_valid
//   mem_en      BRAM enable
//   mem_we      BRAM write enable
//   mem_addr    BRAM address
//   mem_wdata   BRAM write data
//   mem_rdata   BRAM read data (one cycle after a read enable)
//   fifo_level  current write-FIFO occupancy
//   ovf         sticky overflow flag (a write was dropped)
//   ovf_clr     clears ovf; a coincident drop keeps it set

module mask_mem_arbiter #(
    parameter int ADDR_W       = 18,
    parameter int FIFO_DEPTH   = 8,
    parameter int HIGH_WATER   = 6,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          filt_we,
    input  logic [ADDR_W-1:0]             filt_addr,
    input  logic [2:0]                    filt_data,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_gnt,
    output logic                          rd_valid,
    output logic [2:0]                    rd_data,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [2:0]                    mem_wdata,
    input  logic [2:0]                    mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf,
    input  logic                          ovf_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] HW_LVL   = LVL_W'(HIGH_WATER);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    // Write FIFO storage. Small and read asynchronously at the head so the
    // memory port can be driven in the same cycle the pop is decided.
    logic [ADDR_W-1:0] slot_addr [FIFO_DEPTH];
    logic [2:0]        slot_data [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic              ovf_reg;
    logic              rd_valid_reg;

    logic [ADDR_W-1:0] head_addr;
    logic [2:0]        head_data;
    logic              force_read;
    logic              grant_read;
    logic              pop;
    logic              push_ok;
    logic              drop;

    assign head_addr = slot_addr[rd_ptr_reg];
    assign head_data = slot_data[rd_ptr_reg];

`ifdef MASK_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_reg;

    // A read that has waited STARVE_LIMIT cycles beats the high-water rule.
    assign force_read = rd_req && (starve_reg == STARVE_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_reg <= '0;
        end else if (!rd_req || grant_read) begin
            starve_reg <= '0;
        end else if (starve_reg != STARVE_MAX) begin
            starve_reg <= starve_reg + 1'b1;
        end
    end
`else
    assign force_read = 1'b0;
`endif

    // One memory operation per cycle, decided on the registered level.
    // At or above high water a pending read loses unless it is starved;
    // otherwise reads win and the FIFO drains in idle read cycles.
    always_comb begin
        grant_read = 1'b0;
        pop        = 1'b0;
        if (rd_req && (force_read || (level_reg < HW_LVL))) begin
            grant_read = 1'b1;
        end else if (level_reg != '0) begin
            pop = 1'b1;
        end
    end

    // A push into a full FIFO only fits if the head leaves in the same cycle.
    assign push_ok = filt_we && ((level_reg != FULL_LVL) || pop);
    assign drop    = filt_we && !push_ok;

    assign mem_en    = grant_read || pop;
    assign mem_we    = pop;
    assign mem_addr  = pop ? head_addr : (grant_read ? rd_addr : '0);
    assign mem_wdata = pop ? head_data : 3'b000;
    assign rd_gnt    = grant_read;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            slot_addr[wr_ptr_reg] <= filt_addr;
            slot_data[wr_ptr_reg] <= filt_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            ovf_reg      <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
            rd_valid_reg <= grant_read;
        end
    end

    // The BRAM output register is the data stage: mem_rdata already holds
    // the granted read's word in the rd_valid cycle.
    assign rd_valid   = rd_valid_reg;
    assign rd_data    = rd_valid_reg ? mem_rdata : 3'b000;
    assign fifo_level = level_reg;
    assign ovf        = ovf_reg;

endmodule

// File: tb/tb_mask_mem_arbiter.sv
module tb_mask_mem_arbiter;

    localparam int AW    = 18;
    localparam int DEPTH = 8;
    localparam int HW    = 6;
    localparam int SL    = 2;
`ifdef MASK_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          filt_we = 1'b0;
    logic [AW-1:0] filt_addr = '0;
    logic [2:0]    filt_data = '0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          ovf_clr = 1'b0;
    logic          rd_gnt, rd_valid, mem_en, mem_we, ovf;
    logic [2:0]    rd_data, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [3:0]    fifo_level;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mask_mem_arbiter #(
        .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .HIGH_WATER(HW), .STARVE_LIMIT(SL)
    ) dut (
        .clock(clock), .reset(reset),
        .filt_we(filt_we), .filt_addr(filt_addr), .filt_data(filt_data),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fifo_level(fifo_level), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    // BRAM: 4096 words (address bits [11:0]), 1-cycle read latency.
    logic [2:0]  bram [4096];
    bit [4095:0] bram_written;
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) begin
                bram[mem_addr[11:0]]         <= mem_wdata;
                bram_written[mem_addr[11:0]] <= 1'b1;
            end else begin
                mem_rdata <= bram_written[mem_addr[11:0]] ? bram[mem_addr[11:0]] : 3'b000;
            end
        end
    end

    // Reference model: queue of pending writes, committed memory image,
    // expected read response, sticky overflow and starve count.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [2:0]    d;
    } wr_t;

    wr_t        wq[$];
    logic [2:0] ref_mem [4096];
    bit         m_read, m_write, m_ovf, m_rv;
    logic [2:0] m_rd;
    int         m_starve;

    task automatic model_reset();
        wq.delete();
        m_ovf    = 1'b0;
        m_rv     = 1'b0;
        m_rd     = 3'b000;
        m_starve = 0;
    endtask

    task automatic decide();
        m_read  = rd_req && ((wq.size() < HW) || (STARVE_ON && m_starve >= SL));
        m_write = !m_read && (wq.size() > 0);
    endtask

    // Advance one clock: model commits this cycle's operation at the edge.
    task automatic step();
        wr_t w;
        bit  dropped;
        decide();
        @(posedge clock);
        m_rv = m_read;
        m_rd = m_read ? ref_mem[rd_addr[11:0]] : 3'b000;
        if (m_write) begin
            w = wq.pop_front();
            ref_mem[w.a[11:0]] = w.d;
        end
        dropped = filt_we && (wq.size() >= DEPTH);
        if (filt_we && !dropped) begin
            w.a = filt_addr;
            w.d = filt_data;
            wq.push_back(w);
        end
        if (dropped) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        if (!rd_req || m_read) m_starve = 0;
        else if (m_starve < SL) m_starve++;
        @(negedge clock);
    endtask

    task automatic set_idle();
        filt_we = 1'b0; filt_addr = '0; filt_data = '0;
        rd_req = 1'b0; rd_addr = '0; ovf_clr = 1'b0;
    endtask

    task automatic drain();
        set_idle();
        for (int i = 0; i < 4 * DEPTH && wq.size() > 0; i++) step();
        #1;
        checks++;
        if (fifo_level !== 4'd0 || wq.size() != 0) begin
            errors++;
            $display("FAIL drain: fifo_level=%0d model=%0d required 0", fifo_level, wq.size());
        end
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if ({rd_gnt, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata, ovf} !== '0 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b valid=%b en=%b we=%b addr=%h level=%0d ovf=%b required all 0",
                     rd_gnt, rd_valid, mem_en, mem_we, mem_addr, fifo_level, ovf);
        end
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        rd_req = 1'b1; rd_addr = 18'h00010;
        #1;
        checks++;
        if (rd_gnt !== 1'b1) begin
            errors++; $display("FAIL reset_mid_grant: rd_gnt=%b required 1", rd_gnt);
        end
        #3;
        reset = 1'b1; rd_req = 1'b0; rd_addr = '0;
        @(posedge clock); #1;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_valid: rd_valid=%b required 0", rd_valid);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({rd_gnt, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata, ovf} !== '0 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL reset_release: valid=%b en=%b level=%0d ovf=%b required all 0", rd_valid, mem_en, fifo_level, ovf);
        end
        @(posedge clock); #1;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_no_late_valid: rd_valid=%b required 0", rd_valid);
        end
        @(negedge clock);
        $display("reset: mid-read grant discarded");
    endtask

    task automatic test_single_write();
        filt_we = 1'b1; filt_addr = 18'h00123; filt_data = 3'b101;
        #1;
        checks++;
        if (mem_en !== 1'b0) begin
            errors++; $display("FAIL write_no_bypass: mem_en=%b required 0", mem_en);
        end
        step();
        set_idle();
        #1;
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 18'h00123 || mem_wdata !== 3'd5) begin
            errors++;
            $display("FAIL single_write: en=%b we=%b addr=%h data=%0d required 1 1 00123 5", mem_en, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (fifo_level !== 4'd1) begin
            errors++; $display("FAIL single_write_level: fifo_level=%0d required 1", fifo_level);
        end
        step();
        #1;
        checks++;
        if (fifo_level !== 4'd0) begin
            errors++; $display("FAIL single_write_empty: fifo_level=%0d required 0", fifo_level);
        end
        $display("write: addr=00123 data=5");
    endtask

    task automatic test_read_latency();
        logic [2:0] exp_d [3];
        exp_d[0] = 3'd3; exp_d[1] = 3'd5; exp_d[2] = 3'd6;
        for (int i = 0; i < 3; i++) begin
            filt_we = 1'b1; filt_addr = 18'h00040 + 18'(i); filt_data = exp_d[i];
            #1;
            step();
        end
        drain();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                rd_req = 1'b1; rd_addr = 18'h00040 + 18'(i);
            end else begin
                set_idle();
            end
            #1;
            if (i < 3) begin
                checks++;
                if (rd_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 18'h00040 + 18'(i)) begin
                    errors++;
                    $display("FAIL read_grant: gnt=%b en=%b we=%b addr=%h required 1 1 0 %h", rd_gnt, mem_en, mem_we, mem_addr, 18'h00040 + 18'(i));
                end
            end
            if (i > 0) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== exp_d[i-1]) begin
                    errors++;
                    $display("FAIL read_data: valid=%b data=%0d required 1 %0d", rd_valid, rd_data, exp_d[i-1]);
                end else begin
                    $display("read: addr=%h data=%0d", 18'h00040 + 18'(i - 1), rd_data);
                end
            end
            step();
        end
        #1;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL read_single_pulse: rd_valid=%b required 0", rd_valid);
        end
    endtask

    task automatic test_high_water();
        bit saw = 1'b0;
        for (int i = 0; i < 14; i++) begin
            rd_req = 1'b1; rd_addr = 18'h00200;
            filt_we = (i < 6); filt_addr = 18'h00300 + 18'(i); filt_data = 3'(i);
            #1;
            decide();
            checks++;
            if (rd_gnt !== m_read || mem_we !== m_write) begin
                errors++; $display("FAIL hw_arb: gnt=%b we=%b required %b %b", rd_gnt, mem_we, m_read, m_write);
            end
            checks++;
            if (fifo_level !== 4'(wq.size()) || fifo_level > 4'd6) begin
                errors++; $display("FAIL hw_level: fifo_level=%0d required %0d (max 6)", fifo_level, wq.size());
            end
            checks++;
            if (ovf !== 1'b0) begin
                errors++; $display("FAIL hw_ovf: ovf=%b required 0", ovf);
            end
            if (mem_we === 1'b1 && fifo_level === 4'd6) saw = 1'b1;
            step();
        end
        checks++;
        if (!saw) begin
            errors++; $display("FAIL hw_takeover: write at level 6 seen=0 required 1");
        end
        $display("high_water: write took the port at level 6");
        drain();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 30; i++) begin
            rd_req = 1'b1; rd_addr = 18'h00500;
            filt_we = 1'b1; filt_addr = 18'h00600 + 18'(i); filt_data = 3'(i + 1);
            #1;
            decide();
            checks++;
            if (rd_gnt !== m_read || mem_we !== m_write || fifo_level !== 4'(wq.size()) || ovf !== m_ovf) begin
                errors++;
                $display("FAIL ovf_fill: gnt=%b we=%b level=%0d ovf=%b required %b %b %0d %b",
                         rd_gnt, mem_we, fifo_level, ovf, m_read, m_write, wq.size(), m_ovf);
            end
            step();
        end
        set_idle();
        #1;
        checks++;
`ifdef MASK_ARB_STARVE_EN
        if (ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_set: ovf=%b required 1", ovf);
        end
`else
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_never: ovf=%b required 0", ovf);
        end
`endif
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        #1;
        checks++;
        if (ovf !== 1'b0 || m_ovf != 1'b0) begin
            errors++; $display("FAIL ovf_clear: ovf=%b required 0", ovf);
        end
        $display("overflow: flag cleared");
        drain();
    endtask

    task automatic test_ordering();
        filt_we = 1'b1; filt_addr = 18'h00010; filt_data = 3'd1;
        #1; step();
        filt_data = 3'd6;
        #1; step();
        drain();
        rd_req = 1'b1; rd_addr = 18'h00010;
        #1;
        checks++;
        if (rd_gnt !== 1'b1) begin
            errors++; $display("FAIL order_grant: rd_gnt=%b required 1", rd_gnt);
        end
        step();
        set_idle();
        #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 3'd6) begin
            errors++; $display("FAIL order_data: valid=%b data=%0d required 1 6", rd_valid, rd_data);
        end
        $display("ordering: addr=00010 data=%0d", rd_data);
    endtask

    task automatic test_random();
        bit granted_last = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!rd_req || granted_last || $urandom_range(0, 9) == 0) begin
                rd_req  = ($urandom_range(0, 99) < (((i / 100) % 2) != 0 ? 20 : 70));
                rd_addr = {2'($urandom), 12'h000, 4'($urandom)};
            end
            filt_we   = ($urandom_range(0, 99) < 60);
            filt_addr = {2'($urandom), 12'h000, 4'($urandom)};
            filt_data = 3'($urandom);
            ovf_clr   = ($urandom_range(0, 9) == 0);
            #1;
            decide();
            checks++;
            if (rd_gnt !== m_read || mem_en !== (m_read || m_write) || mem_we !== m_write) begin
                errors++;
                $display("FAIL rnd_arb: gnt=%b en=%b we=%b required %b %b %b", rd_gnt, mem_en, mem_we, m_read, m_read || m_write, m_write);
            end
            if (m_write) begin
                checks++;
                if (mem_addr !== wq[0].a || mem_wdata !== wq[0].d) begin
                    errors++; $display("FAIL rnd_wr: addr=%h data=%0d required %h %0d", mem_addr, mem_wdata, wq[0].a, wq[0].d);
                end
            end
            if (m_read) begin
                checks++;
                if (mem_addr !== rd_addr) begin
                    errors++; $display("FAIL rnd_rdaddr: addr=%h required %h", mem_addr, rd_addr);
                end
            end
            checks++;
            if (fifo_level !== 4'(wq.size()) || ovf !== m_ovf || rd_valid !== m_rv) begin
                errors++;
                $display("FAIL rnd_state: level=%0d ovf=%b valid=%b required %0d %b %b", fifo_level, ovf, rd_valid, wq.size(), m_ovf, m_rv);
            end
            if (m_rv) begin
                checks++;
                if (rd_data !== m_rd) begin
                    errors++; $display("FAIL rnd_rdata: data=%0d required %0d", rd_data, m_rd);
                end else begin
                    $display("random read: data=%0d", rd_data);
                end
            end
            granted_last = m_read;
            step();
        end
        drain();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = 3'b000;
        model_reset();
        test_reset();
        test_single_write();
        test_read_latency();
        test_high_water();
        test_overflow();
        test_ordering();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
